// File: rtl/control_multiciclo.sv
// Main control FSM for the multicycle MIPS datapath.
//
// Sequences fetch, decode, execute, memory and write-back over several clocks
// per instruction and drives every datapath mux select and write enable.
// Memory states (FETCH, MEMRD, MEMWR) hold until mem_ready is high.
//
// Optional feature: define CTRL_ADDI_EN to add ADDI support (opcode 001000 runs
// through ADDIEX(10) and ADDIWB(11)). When it is undefined, 001000 is treated as
// an illegal opcode.
//
// Parameters:
//   STATE_W      width of state_dbg; must be >= 4
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   opcode       IR[31:26]
//   zero         ALU zero flag; gated with PCWriteCond in the datapath
//   mem_ready    memory completes the current read/write this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load if zero
//   IorD         memory address select (0 PC, 1 ALUOut)
//   MemRead      memory read request
//   MemWrite     memory write request
//   IRWrite      instruction register load
//   MemtoReg     write-back source (1 MDR, 0 ALUOut)
//   PCSource     PC source (00 ALU, 01 ALUOut, 10 jump target)
//   ALUOp        to the ALU control decoder (00 add, 01 sub, 10 funct)
//   ALUSrcA      ALU A source (0 PC, 1 reg A)
//   ALUSrcB      ALU B source (00 B, 01 4, 10 imm, 11 imm<<2)
//   RegWrite     register file write
//   RegDst       destination register (1 rd, 0 rt)
//   illegal_op   one-cycle pulse on an unknown opcode in DECODE
//   state_dbg    current state encoding
module control_multiciclo #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef CTRL_ADDI_EN
  localparam logic [5:0] OpAddi  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
`ifdef CTRL_ADDI_EN
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11
`else
    StJump   = 4'd9
`endif
  } state_e;

  state_e state_q, state_d;

  // The branch decision is made in the datapath by ANDing zero with PCWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = StFetch;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegal_op  = 1'b0;

    unique case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        // Branch target computed speculatively into ALUOut.
        ALUSrcB = 2'b11;
        unique case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
`ifdef CTRL_ADDI_EN
          OpAddi:     state_d = StAddiEx;
`endif
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is stable, so the opcode can be re-sampled here.
        if (opcode == OpLw) begin
          state_d = StMemRd;
        end else if (opcode == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? StFetch : StMemWr;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = StFetch;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = StFetch;
      end
`ifdef CTRL_ADDI_EN
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
`endif
      default: state_d = StFetch;
    endcase

    // A cycle that samples reset must not commit any architectural write.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_control_multiciclo.sv
// Scoreboard bench for control_multiciclo: the stimulus process walks each
// instruction through its phase list and queues the expected outputs of every
// cycle; a monitor at the falling edge pops and compares.
module tb_control_multiciclo;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r;
    logic [1:0] pcs, aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       rw, rdst, ill;
  } out_t;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state_dbg;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  control_multiciclo #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  function automatic logic known_op(input logic [5:0] op);
`ifdef CTRL_ADDI_EN
    if (op == ADDI) return 1'b1;
`endif
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == JMP);
  endfunction

  // Output table for one phase of an instruction.
  function automatic out_t phase_out(input int ph, input logic mr, input logic ill);
    out_t e;
    e    = '0;
    e.st = 4'(ph);
    case (ph)
      0:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
      1:  begin e.srcb = 2'b11; e.ill = ill; end
      2:  begin e.srca = 1; e.srcb = 2'b10; end
      3:  begin e.mrd = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 1; end
      5:  begin e.mwr = 1; e.iord = 1; end
      6:  begin e.srca = 1; e.aluop = 2'b10; end
      7:  begin e.rw = 1; e.rdst = 1; end
      8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; end
      9:  begin e.pcw = 1; e.pcs = 2'b10; end
      10: begin e.srca = 1; e.srcb = 2'b10; end
      11: begin e.rw = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Drive one cycle and queue what the DUT must show during it.
  task automatic step(input logic rst, input logic mr, input logic [5:0] op, input int ph,
                      input logic ill);
    out_t e;
    e = phase_out(ph, mr, ill);
    if (rst) begin
      e.pcw = 0; e.pcwc = 0; e.irw = 0; e.rw = 0; e.mwr = 0;
    end
    reset     = rst;
    mem_ready = mr;
    opcode    = op;
    zero      = 1'($urandom_range(0, 1));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // A memory phase held for 'waits' not-ready cycles, then completed.
  task automatic mem_phase(input int ph, input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++) step(1'b0, 1'b0, op, ph, 1'b0);
    step(1'b0, 1'b1, op, ph, 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    mem_phase(0, 6'($urandom), wf);
    step(1'b0, 1'($urandom_range(0, 1)), op, 1, !known_op(op));
    case (op)
      LW: begin
        step(1'b0, 1'($urandom_range(0, 1)), op, 2, 1'b0);
        mem_phase(3, op, wm);
        step(1'b0, 1'($urandom_range(0, 1)), op, 4, 1'b0);
      end
      SW: begin
        step(1'b0, 1'($urandom_range(0, 1)), op, 2, 1'b0);
        mem_phase(5, op, wm);
      end
      RT: begin
        step(1'b0, 1'($urandom_range(0, 1)), op, 6, 1'b0);
        step(1'b0, 1'($urandom_range(0, 1)), op, 7, 1'b0);
      end
      BEQ: step(1'b0, 1'($urandom_range(0, 1)), op, 8, 1'b0);
      JMP: step(1'b0, 1'($urandom_range(0, 1)), op, 9, 1'b0);
`ifdef CTRL_ADDI_EN
      ADDI: begin
        step(1'b0, 1'($urandom_range(0, 1)), op, 10, 1'b0);
        step(1'b0, 1'($urandom_range(0, 1)), op, 11, 1'b0);
      end
`endif
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    out_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{st: state_dbg, pcw: PCWrite, pcwc: PCWriteCond, iord: IorD, mrd: MemRead,
            mwr: MemWrite, irw: IRWrite, m2r: MemtoReg, pcs: PCSource, aluop: ALUOp,
            srca: ALUSrcA, srcb: ALUSrcB, rw: RegWrite, rdst: RegDst, ill: illegal_op};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t state got %0d want %0d, vector got %h want %h",
                 $time, a.st, e.st, a, e);
      end
      checks++;
      if (MemRead === 1'b1 && MemWrite === 1'b1) begin
        errors++;
        $display("FAIL rd_wr_exclusive t=%0t got both high, want at most one", $time);
      end
    end
  end

  initial begin
    logic [5:0] op;
    reset = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
    @(posedge clk);
    #1;
    // Reset still high in FETCH with mem_ready=1: no PC/IR load allowed.
    step(1'b1, 1'b1, RT, 0, 1'b0);

    run_instr(LW, 0, 0);
    run_instr(RT, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(SW, 2, 3);
    run_instr(6'b111111, 0, 0);
    run_instr(ADDI, 0, 0);
    run_instr(JMP, 1, 0);

    // Reset while LW waits in MEMRD: instruction abandoned, back to FETCH.
    mem_phase(0, RT, 0);
    step(1'b0, 1'b1, LW, 1, 1'b0);
    step(1'b0, 1'b1, LW, 2, 1'b0);
    step(1'b0, 1'b0, LW, 3, 1'b0);
    step(1'b1, 1'b1, LW, 3, 1'b0);
    run_instr(RT, 0, 0);

    for (int n = 0; n < 120; n++) begin
      int k;
      k = $urandom_range(0, 7);
      case (k)
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = JMP;
        5: op = ADDI;
        6: begin
          op = 6'($urandom);
          for (int t = 0; t < 16 && known_op(op); t++) op = 6'($urandom);
          if (known_op(op)) op = 6'b111111;
        end
        default: op = RT;
      endcase
      if (k == 7) step(1'b1, 1'($urandom_range(0, 1)), op, 0, 1'b0);
      else run_instr(op, $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
                     $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
